// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: pixel-rate timing, framebuffer address generation,
// 16-entry palette lookup and registered RGB/sync outputs.
module vga_scanout #(
    parameter int CLK_DIV   = 4,
    parameter int SCALE     = 2,
    parameter int FB_WIDTH  = 320,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] addr_vga,
    input  logic [3:0]  data_vga,
    input  logic        pal_wr_en,
    input  logic [3:0]  pal_wr_idx,
    input  logic [11:0] pal_wr_rgb,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = $clog2(CLK_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d, hx_q, hx_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    hsub_q, hsub_d, vsub_q, vsub_d;
    logic [18:0]   row_q, row_d, addr_q, addr_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [11:0]   pal_q [16];
    logic          tick, vis_cur, vis_nxt;

    assign tick    = (int'(div_q) == CLK_DIV - 1);
    // vis_cur: pixel whose address is currently registered (output stage);
    // vis_nxt: pixel the counters move to on this tick (address stage).
    assign vis_cur = (int'(h_q) < H_VISIBLE) && (int'(v_q) < V_VISIBLE);
    assign vis_nxt = (int'(h_d) < H_VISIBLE) && (int'(v_d) < V_VISIBLE);

    always_comb begin
        div_d  = tick ? '0 : div_q + 1'b1;
        h_d    = h_q;
        hx_d   = hx_q;
        hsub_d = hsub_q;
        v_d    = v_q;
        vsub_d = vsub_q;
        row_d  = row_q;
        if (tick) begin
            if (int'(h_q) == H_TOTAL - 1) begin
                h_d    = '0;
                hx_d   = '0;
                hsub_d = '0;
                if (int'(v_q) == V_TOTAL - 1) begin
                    v_d    = '0;
                    vsub_d = '0;
                    row_d  = '0;
                end else begin
                    v_d = v_q + 1'b1;
                    // Row base advances by one framebuffer row every SCALE lines.
                    if (int'(vsub_q) == SCALE - 1) begin
                        vsub_d = '0;
                        row_d  = row_q + 19'(FB_WIDTH);
                    end else begin
                        vsub_d = vsub_q + 1'b1;
                    end
                end
            end else begin
                h_d = h_q + 1'b1;
                if (int'(hsub_q) == SCALE - 1) begin
                    hsub_d = '0;
                    hx_d   = hx_q + 1'b1;
                end else begin
                    hsub_d = hsub_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        rgb_d  = rgb_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        fs_d   = 1'b0;
        if (tick) begin
            addr_d = vis_nxt ? row_d + 19'(hx_d) : '0;
            // data_vga belongs to the pixel addressed on the previous tick.
            rgb_d  = vis_cur ? pal_q[data_vga] : '0;
            hs_d   = !((int'(h_q) >= HS_START) && (int'(h_q) < HS_END));
            vs_d   = !((int'(v_q) >= VS_START) && (int'(v_q) < VS_END));
            fs_d   = vs_q && !vs_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            h_q    <= '0;
            hx_q   <= '0;
            hsub_q <= '0;
            v_q    <= '0;
            vsub_q <= '0;
            row_q  <= '0;
            addr_q <= '0;
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            hx_q   <= hx_d;
            hsub_q <= hsub_d;
            v_q    <= v_d;
            vsub_q <= vsub_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) pal_q[i] <= {4'(i), 4'(i), 4'(i)};
        end else if (pal_wr_en) begin
            pal_q[pal_wr_idx] <= pal_wr_rgb;
        end
    end

    assign addr_vga    = addr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster (24x18 pixels, 16x12 visible) so
// whole frames fit in a short run; a second instance covers SCALE=1.
module tb_vga_scanout;
    localparam int CD   = 2;
    localparam int HV   = 16, HF = 2, HS = 4, HB = 2;
    localparam int VV   = 12, VF = 2, VS = 2, VB = 2;
    localparam int HT   = HV + HF + HS + HB;
    localparam int VT   = VV + VF + VS + VB;
    localparam int FR   = HT * VT;
    localparam int FBW2 = HV / 2;
    localparam int FBW1 = HV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pal_wr_en = 1'b0;
    logic [3:0]  pal_wr_idx = '0;
    logic [11:0] pal_wr_rgb = '0;
    logic [18:0] addr2, addr1;
    logic [3:0]  data2 = '0, data1 = '0;
    logic [3:0]  r2, g2, b2, r1, g1, b1;
    logic        hs2, vs2, fs2, hs1, vs1, fs1;

    always #5 clock = ~clock;

    vga_scanout #(.CLK_DIV(CD), .SCALE(2), .FB_WIDTH(FBW2),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut (
        .clock(clock), .reset(reset), .addr_vga(addr2), .data_vga(data2),
        .pal_wr_en(pal_wr_en), .pal_wr_idx(pal_wr_idx), .pal_wr_rgb(pal_wr_rgb),
        .vga_r(r2), .vga_g(g2), .vga_b(b2), .hsync(hs2), .vsync(vs2), .frame_start(fs2));

    vga_scanout #(.CLK_DIV(CD), .SCALE(1), .FB_WIDTH(FBW1),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut1 (
        .clock(clock), .reset(reset), .addr_vga(addr1), .data_vga(data1),
        .pal_wr_en(pal_wr_en), .pal_wr_idx(pal_wr_idx), .pal_wr_rgb(pal_wr_rgb),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .hsync(hs1), .vsync(vs1), .frame_start(fs1));

    int checks = 0, failures = 0;
    int seed = 0;
    // Reference state: clocks since release, pixel ticks since release.
    int c, T;
    logic [11:0] pal_m [16];
    logic [18:0] e_addr2, e_addr1;
    logic [11:0] e_rgb;
    logic        e_hs, e_vs, e_fs;
    logic        prev_hs, prev_vs;
    int          hs_fall, vs_fall;

    function automatic int addr_of(int p, int sc, int fbw);
        int h = p % HT;
        int v = p / HT;
        if (h < HV && v < VV) return (v / sc) * fbw + h / sc;
        return 0;
    endfunction

    function automatic logic [3:0] bram(logic [18:0] a);
        return 4'((int'(a) + seed) & 15);
    endfunction

    // One-clock-latency framebuffer models.
    always @(posedge clock) begin
        data2 <= bram(addr2);
        data1 <= bram(addr1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (clk %0d tick %0d)", name, act, exp, c, T);
        end
    endtask

    task automatic model_reset();
        c = 0;
        T = 0;
        for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
        e_addr2 = '0; e_addr1 = '0; e_rgb = '0;
        e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        hs_fall = -1; vs_fall = -1;
    endtask

    task automatic model_edge();
        int q, h, v;
        if (reset) begin
            model_reset();
            return;
        end
        c++;
        e_fs = 1'b0;
        if (c % CD == 0) begin
            T++;
            q = (T - 1) % FR;
            h = q % HT;
            v = q / HT;
            e_addr2 = 19'(addr_of(T % FR, 2, FBW2));
            e_addr1 = 19'(addr_of(T % FR, 1, FBW1));
            e_rgb   = (h < HV && v < VV) ? pal_m[bram(19'(addr_of(q, 2, FBW2)))] : 12'h000;
            e_hs    = !(h >= HV + HF && h < HV + HF + HS);
            e_vs    = !(v >= VV + VF && v < VV + VF + VS);
            e_fs    = (q == (VV + VF) * HT);
        end
        if (pal_wr_en) pal_m[pal_wr_idx] = pal_wr_rgb;
    endtask

    task automatic check();
        chk("addr", addr2, e_addr2);
        chk("addr_scale1", addr1, e_addr1);
        chk("rgb", {r2, g2, b2}, e_rgb);
        chk("hs_vs_fs", {hs2, vs2, fs2}, {e_hs, e_vs, e_fs});
        if (!reset) begin
            if (prev_hs && !hs2) begin
                if (hs_fall >= 0) chk("hsync_period", c - hs_fall, HT * CD);
                hs_fall = c;
            end
            if (!prev_hs && hs2 && hs_fall >= 0) chk("hsync_width", c - hs_fall, HS * CD);
            if (prev_vs && !vs2) begin
                chk("fs_align", fs2, 1);
                // Sync lags the counters by one pixel.
                if (vs_fall < 0) chk("first_vsync", c, (VV + VF) * HT * CD + CD);
                else             chk("frame_period", c - vs_fall, FR * CD);
                vs_fall = c;
            end
            if (!prev_vs && vs2 && vs_fall >= 0) chk("vsync_width", c - vs_fall, VS * HT * CD);
            prev_hs = hs2;
            prev_vs = vs2;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check();
    endtask

    // pre=1: stop just before the tick that outputs pixel p; pre=0: just after counters reach p.
    task automatic wait_pix(input int p, input bit pre, input string nm);
        bit hit = 1'b0;
        for (int k = 0; k < 3 * FR * CD; k++) begin
            hit = pre ? (((c + 1) % CD == 0) && (T % FR == p))
                      : ((c % CD == 0) && (T % FR == p) && (T > 0 || p == 0));
            if (hit) break;
            step();
        end
        if (!hit) begin
            failures++;
            $display("FAIL %s: pixel %0d not reached within cycle budget", nm, p);
        end
    endtask

    typedef struct { int h; int v; int a2; int a1; } vec_t;
    vec_t tbl [10];

    initial begin
        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1};
        tbl[2] = '{2, 0, 1, 2};
        tbl[3] = '{16, 0, 0, 0};
        tbl[4] = '{0, 1, 0, 16};
        tbl[5] = '{1, 1, 0, 17};
        tbl[6] = '{0, 2, 8, 32};
        tbl[7] = '{5, 3, 10, 53};
        tbl[8] = '{15, 11, 47, 191};
        tbl[9] = '{3, 12, 0, 0};

        model_reset();
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;

        foreach (tbl[i]) begin
            wait_pix(tbl[i].v * HT + tbl[i].h, 1'b0, "table_wait");
            chk($sformatf("tbl%0d_addr", i), addr2, tbl[i].a2);
            chk($sformatf("tbl%0d_addr_s1", i), addr1, tbl[i].a1);
        end

        // Index 5 addressed at (10,0) appears one pixel later as grey 0x555.
        wait_pix(10, 1'b0, "lat_wait");
        chk("lat_addr", addr2, 5);
        wait_pix(11, 1'b0, "lat_wait2");
        chk("lat_rgb", {r2, g2, b2}, 12'h555);

        // Write index 3 on the very edge that looks it up for pixel (6,1).
        wait_pix(HT + 6, 1'b1, "pal_wait");
        pal_wr_en = 1'b1; pal_wr_idx = 4'd3; pal_wr_rgb = 12'hF00;
        step();
        pal_wr_en = 1'b0;
        chk("pal_same_clk", {r2, g2, b2}, 12'h333);
        for (int i = 0; i < CD; i++) step();
        chk("pal_new", {r2, g2, b2}, 12'hF00);

        // Random palette traffic over two frames with a random framebuffer pattern.
        for (int k = 0; k < CD && (c % CD != 0); k++) step();
        seed = int'($urandom_range(0, 15));
        for (int k = 0; k < 2 * FR * CD + 50; k++) begin
            pal_wr_en  = ($urandom_range(0, 3) == 0);
            pal_wr_idx = 4'($urandom_range(0, 15));
            pal_wr_rgb = 12'($urandom_range(0, 4095));
            step();
        end
        pal_wr_en = 1'b0;

        // Asynchronous reset mid-line, between clock edges.
        wait_pix(5 * HT + 10, 1'b0, "rst_wait");
        #2 reset = 1'b1;
        #1;
        chk("arst_addr", addr2, 0);
        chk("arst_rgb", {r2, g2, b2}, 0);
        chk("arst_sync", {hs2, vs2, fs2}, 3'b110);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < (VV + VF) * HT * CD + CD + 10; k++) step();
        chk("first_vsync_seen", (vs_fall >= 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of the framebuffer read port.
- Generates 640x480@60 VGA timing from the system clock and issues framebuffer read addresses on `addr_vga`.
- Takes the returned 4-bit palette index on `data_vga` and maps it through a programmable 16-entry palette to 12-bit RGB.
- Drives `vsync`, which the framebuffer master uses to swap buffers at the start of each vsync pulse.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range is 2 or more.
- SCALE, 2, pixel replication factor in both axes; legal values are 1 and 2.
- FB_WIDTH, 320, framebuffer row width in pixels; equals 640/SCALE.
- H_VISIBLE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal timing in pixels.
- V_VISIBLE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical timing in lines.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- addr_vga  out  19  framebuffer read address.
- data_vga  in  4  palette index returned one clock after `addr_vga`.
- pal_wr_en  in  1  palette write strobe.
- pal_wr_idx  in  4  palette entry to write.
- pal_wr_rgb  in  12  {R[3:0],G[3:0],B[3:0]}.
- vga_r / vga_g / vga_b  out  4 each  colour outputs.
- hsync  out  1  active-low.
- vsync  out  1  active-low.
- frame_start  out  1  one-clock pulse coincident with `vsync` falling.

Behaviour:
- Reset (async assert, sync deassert internally): divider=0, h=0, v=0, `addr_vga`=0, RGB=0, `hsync`=1, `vsync`=1, `frame_start`=0; palette entry i = {i,i,i}.
- Pixel tick: asserted for one clock when the divider wraps from CLK_DIV-1 to 0. The first tick occurs CLK_DIV clocks after reset deasserts.
- Counters on each tick:
  - h = 0..799; wraps to 0 after 799.
  - v increments when h wraps; v = 0..524, wraps to 0.
  - All other state holds between ticks.
- Address stage, on each tick, after the counters update to (h,v):
  - if h<640 and v<480: `addr_vga` <= (v/SCALE)*FB_WIDTH + (h/SCALE), 19-bit unsigned, max 76799 at defaults;
  - else `addr_vga` <= 0.
  - Implemented with a row-base accumulator and a replication sub-counter; no multiplier.
- Data stage: BRAM latency is one clock, so `data_vga` is valid from the clock after the address registers. It is sampled on the next tick (CLK_DIV clocks later).
- Output stage, on that next tick:
  - RGB <= palette[`data_vga`] if the delayed (h,v) is visible, else 0.
  - `hsync` <= 0 iff delayed h in 656..751.
  - `vsync` <= 0 iff delayed v in 490..491.
  - RGB, syncs and blanking therefore all lag the counters by exactly one pixel and stay mutually aligned.
- `frame_start`: 1 for exactly one clock, on the clock in which `vsync` goes 1->0.
- Palette: 16x12 register file.
  - Writes occur on any clock with `pal_wr_en`=1, regardless of the tick.
  - A lookup on the same clock as a write to the same index returns the old value; the new value is seen from the next clock.
- Simultaneous h and v wrap at (799,524): h=0, v=0, and the first visible address is 0.
- Reset mid-frame: all counters and outputs return to reset values immediately. The palette returns to the grey ramp.

Test Plan:
- Timing: reset, run 2 frames at defaults.
  - `hsync` low pulse = 96 pixels = 384 clocks, period 3200 clocks.
  - `vsync` low pulse = 2 lines = 6400 clocks, frame = 1,680,000 clocks.
  - `frame_start` exactly one pulse per frame, aligned to `vsync` fall.
- Addressing: BRAM model returns addr[3:0].
  - Pixels (0,0),(1,0),(2,0) read addresses 0,0,1.
  - Line 1 repeats line 0's addresses; line 2 starts at 320.
  - Pixel (639,479) reads 76799.
  - `addr_vga`=0 in blanking.
- Latency/alignment: `data_vga` index 5 at pixel (10,0) with default palette.
  - RGB=0x555 on the tick after (10,0)'s address tick.
  - RGB=0 on every blanking pixel.
- Palette: write idx 3 = 0xF00 mid-line while idx 3 is displayed.
  - Same-clock lookup shows 0x333; following pixels show 0xF00.
- Async reset mid-line at h=300,v=200, asserted between clock edges.
  - Outputs go to reset values without waiting for a clock edge.
  - After release, the first `vsync` fall occurs exactly 490 lines later.
- SCALE=1, FB_WIDTH=640: pixel (639,479) reads 307199; no address repeats within a line.
